// File: rtl/rx_media4_pkg.sv
// Shared constants for rx_media4: state encodings, widths, and the
// command/condition bundles exchanged between control and operative parts.
package rx_media4_pkg;

    localparam int DATA_W = 8;
    localparam int GROUP  = 4;
    localparam int ACC_W  = 10;
    localparam int CNT_W  = 2;

    typedef enum logic [2:0] {
        R0 = 3'd0,
        R1 = 3'd1,
        T0 = 3'd2,
        T1 = 3'd3,
        T2 = 3'd4
    } star_t;

    typedef struct packed {
        logic capture;
        logic rfd_up;
        logic load_media;
        logic dav_down;
        logic dav_up_clr;
    } cmd_t;

    typedef struct packed {
        logic c0;
        logic c1;
        logic c2;
    } cond_t;

endpackage

// File: rtl/rx_media4_if.sv
// Upstream byte link and downstream result link of rx_media4.
interface rx_media4_if;
    import rx_media4_pkg::*;

    logic [DATA_W-1:0] byte_in;
    logic              dav_;
    logic              rfd;
    logic [DATA_W-1:0] media;
    logic              out_dav_;
    logic              out_rfd;

    modport slave (
        input  byte_in, dav_, out_rfd,
        output rfd, media, out_dav_
    );

    modport master (
        output byte_in, dav_, out_rfd,
        input  rfd, media, out_dav_
    );

endinterface

// File: rtl/rx_media4_pc.sv
// Control part: the STAR sequencer that walks receive (R*) and transmit (T*)
// phases and issues Mealy-style commands to the operative part.
module rx_media4_pc
    import rx_media4_pkg::*;
(
    input  logic  clock,
    input  logic  reset_,
    input  cond_t cond,
    output cmd_t  cmd
);

    star_t star, star_nxt;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_)
            star <= R0;
        else
            star <= star_nxt;
    end

    always_comb begin
        star_nxt = star;
        cmd      = '0;
        unique case (star)
            R0: begin
                if (cond.c0) begin
                    cmd.capture = 1'b1;
                    star_nxt    = R1;
                end
            end
            R1: begin
                // Waiting for dav_ to rise is what prevents double captures.
                if (!cond.c0) begin
                    cmd.rfd_up = 1'b1;
                    if (cond.c1) begin
                        cmd.load_media = 1'b1;
                        star_nxt       = T0;
                    end else begin
                        star_nxt = R0;
                    end
                end
            end
            T0: begin
                cmd.dav_down = 1'b1;
                star_nxt     = T1;
            end
            T1: begin
                if (!cond.c2) begin
                    cmd.dav_up_clr = 1'b1;
                    star_nxt       = T2;
                end
            end
            T2: begin
                if (cond.c2)
                    star_nxt = R0;
            end
            default: star_nxt = R0;
        endcase
    end

endmodule

// File: rtl/rx_media4_po.sv
// Operative part: accumulator, group counter, mean register and the two
// handshake output registers, all steered by commands from the control part.
module rx_media4_po
    import rx_media4_pkg::*;
(
    input  logic              clock,
    input  logic              reset_,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              dav_,
    input  logic              out_rfd,
    input  cmd_t              cmd,
    output cond_t             cond,
    output logic              rfd,
    output logic [DATA_W-1:0] media,
    output logic              out_dav_
);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    // Sum of GROUP bytes divided by GROUP, dropping the fraction.
    function automatic logic [DATA_W-1:0] trunc_mean(input logic [ACC_W-1:0] sum);
        return DATA_W'(sum >> $clog2(GROUP));
    endfunction

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            acc      <= '0;
            cnt      <= '0;
            media    <= '0;
            rfd      <= 1'b1;
            out_dav_ <= 1'b1;
        end else begin
            if (cmd.capture) begin
                acc <= acc + ACC_W'(byte_in);
                cnt <= cnt + 1'b1;
                rfd <= 1'b0;
            end
            if (cmd.rfd_up)
                rfd <= 1'b1;
            if (cmd.load_media)
                media <= trunc_mean(acc);
            if (cmd.dav_down)
                out_dav_ <= 1'b0;
            if (cmd.dav_up_clr) begin
                out_dav_ <= 1'b1;
                acc      <= '0;
            end
        end
    end

    // cnt wraps to zero exactly when the fourth byte of a group has been taken.
    assign cond.c0 = ~dav_;
    assign cond.c1 = (cnt == '0);
    assign cond.c2 = out_rfd;

endmodule

// File: rtl/rx_media4.sv
// Four-sample truncated-mean receiver: consumes bytes on a dav_/rfd link and
// forwards each group mean on a second dav_/rfd link, stalling upstream meanwhile.
module rx_media4
    import rx_media4_pkg::*;
(
    input  logic         clock,
    input  logic         reset_,
    rx_media4_if.slave   bus
);

    cmd_t  cmd;
    cond_t cond;

    rx_media4_pc u_pc (
        .clock  (clock),
        .reset_ (reset_),
        .cond   (cond),
        .cmd    (cmd)
    );

    rx_media4_po u_po (
        .clock    (clock),
        .reset_   (reset_),
        .byte_in  (bus.byte_in),
        .dav_     (bus.dav_),
        .out_rfd  (bus.out_rfd),
        .cmd      (cmd),
        .cond     (cond),
        .rfd      (bus.rfd),
        .media    (bus.media),
        .out_dav_ (bus.out_dav_)
    );

endmodule

// File: tb/tb_rx_media4.sv
// Scoreboard bench for rx_media4: stimulus queues expected means, a monitor
// checks them when out_dav_ falls, and a responder plays the downstream peer.
module tb_rx_media4;
    import rx_media4_pkg::*;

    logic clock  = 1'b0;
    logic reset_ = 1'b1;
    rx_media4_if bus();

    rx_media4 dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int         vectors = 0;
    int         misc    = 0;
    int         ds_hold = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        misc++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    task automatic wait_rfd(input logic v, input string name);
        int n = 0;
        while (bus.rfd !== v && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (bus.rfd !== v) timeout(name);
    endtask

    task automatic wait_out_dav(input logic v, input string name);
        int n = 0;
        while (bus.out_dav_ !== v && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (bus.out_dav_ !== v) timeout(name);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        bus.byte_in = b;
        bus.dav_    = 1'b0;
        wait_rfd(1'b0, "rfd_fall");
        bus.dav_ = 1'b1;
        wait_rfd(1'b1, "rfd_rise");
    endtask

    task automatic send_group(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [7:0] mean);
        exp_q.push_back(mean);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    // Monitor: one scoreboard pop per falling edge of out_dav_.
    initial begin
        logic       prev;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (prev === 1'b1 && bus.out_dav_ === 1'b0) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    misc++;
                    $display("FAIL unexpected_result: got media %0d, expected none", bus.media);
                end else begin
                    e = exp_q.pop_front();
                    check("media", 32'(bus.media), 32'(e));
                end
            end
            prev = bus.out_dav_;
        end
    end

    // Downstream peer: acknowledges after ds_hold cycles, releases when out_dav_ rises.
    initial begin
        bus.out_rfd = 1'b1;
        forever begin
            @(negedge clock);
            if (bus.out_dav_ === 1'b0) begin
                int n;
                repeat (ds_hold) @(negedge clock);
                bus.out_rfd = 1'b0;
                n = 0;
                while (bus.out_dav_ !== 1'b1 && n < 300) begin
                    @(negedge clock);
                    n++;
                end
                if (bus.out_dav_ !== 1'b1) timeout("out_dav_rise");
                @(negedge clock);
                bus.out_rfd = 1'b1;
            end
        end
    end

    initial begin
        int bad;
        int n;
        bus.byte_in = '0;
        bus.dav_    = 1'b1;

        #1 reset_ = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_rfd", 32'(bus.rfd), 32'd1);
        check("reset_out_dav", 32'(bus.out_dav_), 32'd1);
        check("reset_media", 32'(bus.media), 32'd0);
        reset_ = 1'b1;

        send_group(8'd10, 8'd20, 8'd30, 8'd40, 8'd25);
        wait_out_dav(1'b0, "grp_a_out_dav_fall");
        wait_out_dav(1'b1, "grp_a_out_dav_rise");
        repeat (3) @(negedge clock);
        check("acc_cleared", 32'(dut.u_po.acc), 32'd0);
        check("back_in_r0", 32'(dut.u_pc.star), 32'(R0));

        send_group(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
        send_group(8'd1, 8'd1, 8'd1, 8'd0, 8'd0);

        // Downstream stalls; a pending upstream byte must not be taken.
        ds_hold = 20;
        send_group(8'd2, 8'd2, 8'd2, 8'd2, 8'd2);
        bus.byte_in = 8'd7;
        bus.dav_    = 1'b0;
        bad = 0;
        repeat (15) begin
            @(negedge clock);
            if (bus.rfd !== 1'b1) bad++;
        end
        check("stall_rfd_high", 32'(bad), 32'd0);
        send_group(8'd7, 8'd9, 8'd11, 8'd13, 8'd10);
        ds_hold = 0;

        // Upstream holds dav_ low for 10 clocks on the first byte.
        exp_q.push_back(8'd75);
        @(negedge clock);
        bus.byte_in = 8'd100;
        bus.dav_    = 1'b0;
        wait_rfd(1'b0, "hold_rfd_fall");
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus.rfd !== 1'b0) bad++;
        end
        check("hold_rfd_low", 32'(bad), 32'd0);
        bus.dav_ = 1'b1;
        wait_rfd(1'b1, "hold_rfd_rise");
        send_byte(8'd50);
        send_byte(8'd60);
        send_byte(8'd90);

        // Reset mid-group with rfd low; dav_ is still low when reset releases.
        wait_out_dav(1'b1, "pre_reset_idle");
        repeat (4) @(negedge clock);
        send_byte(8'd5);
        @(negedge clock);
        bus.byte_in = 8'd6;
        bus.dav_    = 1'b0;
        wait_rfd(1'b0, "partial_rfd_fall");
        #2 reset_ = 1'b0;
        #1;
        check("async_rfd", 32'(bus.rfd), 32'd1);
        check("async_out_dav", 32'(bus.out_dav_), 32'd1);
        check("async_media", 32'(bus.media), 32'd0);
        bus.byte_in = 8'd4;
        repeat (2) @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);
        check("capture_after_reset", 32'(bus.rfd), 32'd0);
        send_group(8'd4, 8'd8, 8'd12, 8'd16, 8'd10);

        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
